if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the ID decode block.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake, which tolerates variable latency.
- Presents {pc, inst} to ID through a single-entry output register with valid/ready.
- Accepts taken-branch/jump redirects from EX and squashes the in-flight and held instructions.

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack memory
// handshake and hands {pc, inst} to decode through a single-entry output register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // kill_q marks an outstanding request whose data must be dropped because a
  // redirect arrived before its ack; the address itself cannot move until then.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    pc_out_d   = pc_out_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          if (kill_q || redirect_i) begin
            kill_d = 1'b0;
            if (redirect_i) begin
              req_addr_d = align_word(redirect_addr_i);
              pc_d       = align_word(redirect_addr_i);
            end else begin
              req_addr_d = align_word(pc_q);
            end
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = req_addr_q;
            valid_d  = 1'b1;
            pc_d     = req_addr_q + 32'd4;
            state_d  = HOLD;
          end
        end else begin
          if (redirect_i) begin
            pc_d   = align_word(redirect_addr_i);
            kill_d = 1'b1;
          end else begin
            kill_d = kill_q;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          valid_d    = 1'b0;
          inst_d     = NOP_INST;
          pc_d       = align_word(redirect_addr_i);
          req_addr_d = align_word(redirect_addr_i);
          state_d    = FETCH;
        end else if (id_ready_i) begin
          cnt_d      = cnt_q + 32'd1;
          valid_d    = 1'b0;
          inst_d     = NOP_INST;
          req_addr_d = pc_q;
          state_d    = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
        inst_d  = NOP_INST;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      pc_out_q   <= 32'h0000_0000;
      inst_q     <= NOP_INST;
      cnt_q      <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
    end
  end

  // Gated by rst so an in-flight request disappears the moment reset asserts.
  assign imem_req     = (state_q == FETCH) & ~rst;
  assign imem_addr    = req_addr_q;
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized
// redirect/stall/latency traffic checked against a transaction-level model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] fetch_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .id_ready_i      (id_ready_i),
    .inst_valid_o    (inst_valid_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory responder: ack after `lat` extra cycles of a request (lat<0 picks random 0..3).
  int          fixed_lat = 0;
  int          cur_lat = 0;
  int          wait_c = 0;
  bit          busy = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  always @(negedge clk) begin
    #1;
    if (imem_req === 1'b1) begin
      if (!busy || imem_addr !== cur_addr) begin
        busy     = 1'b1;
        cur_addr = imem_addr;
        wait_c   = 0;
        cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (wait_c == cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        busy       = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_c++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      busy       = 1'b0;
    end
  end

  // Transaction-level reference: next delivered PC and delivered-instruction count.
  bit          mon_en = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_cnt = 32'h0;
  logic        s_valid, s_req, s_ack, s_red, s_rdy;
  logic [31:0] s_pc, s_inst, s_addr, s_tgt;
  always @(posedge clk) begin
    if (mon_en && !rst) begin
      s_valid = inst_valid_o; s_pc = pc_o; s_inst = inst_o;
      s_req = imem_req; s_addr = imem_addr; s_ack = imem_ack;
      s_red = redirect_i; s_tgt = redirect_addr_i; s_rdy = id_ready_i;
      #1;
      if (s_red) exp_pc = {s_tgt[31:2], 2'b00};
      else if (s_valid && s_rdy) begin
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
      check("rand_cnt", fetch_cnt_o, exp_cnt);
      if (inst_valid_o && !s_valid) begin
        check("rand_pc", pc_o, exp_pc);
        check("rand_inst", inst_o, mem_word(exp_pc));
      end
      if (s_valid && !s_rdy && !s_red) begin
        check("rand_stall_valid", {31'd0, inst_valid_o}, 32'd1);
        check("rand_stall_pc", pc_o, s_pc);
        check("rand_stall_inst", inst_o, s_inst);
      end
      if (!inst_valid_o) check("rand_nop", inst_o, NOP);
      if (s_req && !s_ack && imem_req) check("rand_addr_stable", imem_addr, s_addr);
    end
  end

  // Asserts reset between clock edges, checks the asynchronous reset values, then
  // releases it on a falling edge and checks the first request.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    check("rst_cnt", fetch_cnt_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    redirect_i = 1'b0;
    redirect_addr_i = 32'h0;
    id_ready_i = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;

    // Zero-wait memory, decode always ready.
    fixed_lat = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("zw_valid_hi", {31'd0, inst_valid_o}, 32'd1);
      check("zw_pc", pc_o, 32'(4 * k));
      check("zw_inst", inst_o, mem_word(32'(4 * k)));
      @(negedge clk);
      check("zw_valid_lo", {31'd0, inst_valid_o}, 32'd0);
    end
    check("zw_cnt", fetch_cnt_o, 32'd4);

    // Three-cycle ack latency.
    fixed_lat = 2;
    apply_reset();
    repeat (3) @(negedge clk);
    check("lat_pc0", pc_o, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("lat_req", {31'd0, imem_req}, 32'd1);
      check("lat_addr", imem_addr, 32'h4);
      check("lat_not_yet", {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk);
    end
    check("lat_valid", {31'd0, inst_valid_o}, 32'd1);
    check("lat_pc4", pc_o, 32'h4);
    check("lat_inst4", inst_o, mem_word(32'h4));

    // Redirect while the request at 0x8 is outstanding.
    @(negedge clk);
    check("kill_addr8", imem_addr, 32'h8);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    check("kill_addr_stable", imem_addr, 32'h8);
    @(negedge clk);
    @(negedge clk);
    check("kill_next_addr", imem_addr, 32'h100);
    check("kill_dropped", {31'd0, inst_valid_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("kill_valid", {31'd0, inst_valid_o}, 32'd1);
    check("kill_pc", pc_o, 32'h100);
    check("kill_inst", inst_o, mem_word(32'h100));

    // Stall in HOLD, then redirect with ready in the same cycle.
    id_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      check("stall_pc", pc_o, 32'h100);
      check("stall_inst", inst_o, mem_word(32'h100));
      check("stall_cnt", fetch_cnt_o, 32'd2);
    end
    redirect_i = 1'b1;
    redirect_addr_i = 32'h43;
    id_ready_i = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    check("sq_valid", {31'd0, inst_valid_o}, 32'd0);
    check("sq_inst", inst_o, NOP);
    check("sq_cnt", fetch_cnt_o, 32'd2);
    check("sq_req", {31'd0, imem_req}, 32'd1);
    check("sq_addr", imem_addr, 32'h40);

    // Reset mid-request, then mid-HOLD.
    fixed_lat = 0;
    id_ready_i = 1'b0;
    apply_reset();
    @(negedge clk);
    check("rst_first_valid", {31'd0, inst_valid_o}, 32'd1);
    check("rst_first_pc", pc_o, 32'h0);
    apply_reset();

    // Sequential fetch across the top of the address space.
    id_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFC;
    apply_reset();
    @(negedge clk);
    redirect_i = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr_zero", imem_addr, 32'h0);

    // Randomized traffic against the reference model.
    fixed_lat = -1;
    redirect_i = 1'b0;
    apply_reset();
    exp_pc = 32'h0;
    exp_cnt = 32'h0;
    mon_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      redirect_i = ($urandom_range(0, 7) == 0);
      redirect_addr_i = $urandom;
      id_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    mon_en = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk);
    check("rand_progress", {31'd0, (exp_cnt > 32'd50)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
